// File: rtl/exe_redirect_if.sv
// EXE-stage redirect/hazard bundle between the pipeline datapath and the redirect controller.
// The master side supplies the EXE/ID fields; the slave side returns PC-mux and clear controls.
interface exe_redirect_if #(
    parameter int unsigned CNT_W = 32
);
    logic              exe_is_beq;
    logic              exe_is_bne;
    logic              exe_is_jump;
    logic [31:0]       exe_bpc;
    logic              exe_zero;
    logic              exe_m2reg;
    logic              exe_wreg;
    logic [4:0]        exe_rn;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_use_rs;
    logic              id_use_rt;

    logic              pc_redirect;
    logic [31:0]       pc_target;
    logic              stall;
    logic              flush_if_id;
    logic              flush_id_exe;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output exe_is_beq, exe_is_bne, exe_is_jump, exe_bpc, exe_zero,
               exe_m2reg, exe_wreg, exe_rn, id_rs, id_rt, id_use_rs, id_use_rt,
        input  pc_redirect, pc_target, stall, flush_if_id, flush_id_exe,
               taken_cnt, stall_cnt
    );

    modport slave (
        input  exe_is_beq, exe_is_bne, exe_is_jump, exe_bpc, exe_zero,
               exe_m2reg, exe_wreg, exe_rn, id_rs, id_rt, id_use_rs, id_use_rt,
        output pc_redirect, pc_target, stall, flush_if_id, flush_id_exe,
               taken_cnt, stall_cnt
    );
endinterface

// File: rtl/exe_redirect_ctrl.sv
// Resolves beq/bne/jump in EXE, drives the PC redirect, squashes wrong-path IF/ID and ID/EXE,
// inserts load-use bubbles and keeps saturating taken/stall event counters.
module exe_redirect_ctrl #(
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter int unsigned CNT_W         = 32
) (
    input  logic         clk,
    input  logic         clrn,
    exe_redirect_if.slave bus
);
    localparam int unsigned SQ_W = 3;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t           state;
    logic [SQ_W-1:0]  sq_cnt;
    logic [CNT_W-1:0] taken_q;
    logic [CNT_W-1:0] stall_q;
    logic             taken;
    logic             loaduse;

    // Branch resolution; overlapping is_* flags simply OR together.
    assign taken = bus.exe_is_jump
                 | (bus.exe_is_beq & bus.exe_zero)
                 | (bus.exe_is_bne & ~bus.exe_zero);

    // Register 0 is hard-wired, so a load into it can never create a hazard.
    assign loaduse = bus.exe_m2reg & bus.exe_wreg & (bus.exe_rn != 5'd0)
                   & ((bus.id_use_rs & (bus.id_rs == bus.exe_rn))
                    | (bus.id_use_rt & (bus.id_rt == bus.exe_rn)));

    assign bus.taken_cnt = taken_q;
    assign bus.stall_cnt = stall_q;

    // State, squash countdown and event counters.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state   <= RUN;
            sq_cnt  <= '0;
            taken_q <= '0;
            stall_q <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (taken) begin
                        if (taken_q != '1) taken_q <= taken_q + CNT_W'(1);
                        if (SQUASH_CYCLES > 1) begin
                            state  <= SQUASH;
                            sq_cnt <= SQ_W'(SQUASH_CYCLES - 1);
                        end
                    end else if (loaduse) begin
                        if (stall_q != '1) stall_q <= stall_q + CNT_W'(1);
                    end
                end
                SQUASH: begin
                    sq_cnt <= sq_cnt - SQ_W'(1);
                    if (sq_cnt == SQ_W'(1)) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Mealy control outputs; held low while reset is asserted.
    always_comb begin
        bus.pc_redirect  = 1'b0;
        bus.pc_target    = 32'd0;
        bus.stall        = 1'b0;
        bus.flush_if_id  = 1'b0;
        bus.flush_id_exe = 1'b0;
        if (clrn) begin
            unique case (state)
                RUN: begin
                    if (taken) begin
                        bus.pc_redirect  = 1'b1;
                        bus.pc_target    = bus.exe_bpc;
                        bus.flush_if_id  = 1'b1;
                        bus.flush_id_exe = 1'b1;
                    end else if (loaduse) begin
                        bus.stall        = 1'b1;
                        bus.flush_id_exe = 1'b1;
                    end
                end
                SQUASH: begin
                    bus.flush_if_id  = 1'b1;
                    bus.flush_id_exe = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_redirect_ctrl.sv
// Randomized and directed bench for exe_redirect_ctrl against a cycle-level behavioural model.
// Two instances: SQUASH_CYCLES=2/CNT_W=32 and SQUASH_CYCLES=1/CNT_W=4 share the same stimulus.
module tb_exe_redirect_ctrl;
    logic        clk = 1'b0;
    logic        clrn;
    logic        beq, bne, jmp, zero, m2reg, wreg, use_rs, use_rt;
    logic [31:0] bpc;
    logic [4:0]  rn, rs, rt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance: remaining squash cycles and event counts.
    int     sq_len [2] = '{2, 1};
    longint cnt_max[2] = '{64'hFFFF_FFFF, 64'd15};
    int     sq_left[2];
    longint tk_n   [2];
    longint st_n   [2];

    exe_redirect_if #(.CNT_W(32)) bus_a ();
    exe_redirect_if #(.CNT_W(4))  bus_b ();

    assign bus_a.exe_is_beq = beq;    assign bus_b.exe_is_beq = beq;
    assign bus_a.exe_is_bne = bne;    assign bus_b.exe_is_bne = bne;
    assign bus_a.exe_is_jump = jmp;   assign bus_b.exe_is_jump = jmp;
    assign bus_a.exe_bpc = bpc;       assign bus_b.exe_bpc = bpc;
    assign bus_a.exe_zero = zero;     assign bus_b.exe_zero = zero;
    assign bus_a.exe_m2reg = m2reg;   assign bus_b.exe_m2reg = m2reg;
    assign bus_a.exe_wreg = wreg;     assign bus_b.exe_wreg = wreg;
    assign bus_a.exe_rn = rn;         assign bus_b.exe_rn = rn;
    assign bus_a.id_rs = rs;          assign bus_b.id_rs = rs;
    assign bus_a.id_rt = rt;          assign bus_b.id_rt = rt;
    assign bus_a.id_use_rs = use_rs;  assign bus_b.id_use_rs = use_rs;
    assign bus_a.id_use_rt = use_rt;  assign bus_b.id_use_rt = use_rt;

    exe_redirect_ctrl #(.SQUASH_CYCLES(2), .CNT_W(32)) dut_a (.clk(clk), .clrn(clrn), .bus(bus_a));
    exe_redirect_ctrl #(.SQUASH_CYCLES(1), .CNT_W(4))  dut_b (.clk(clk), .clrn(clrn), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        beq = 0; bne = 0; jmp = 0; zero = 0; m2reg = 0; wreg = 0;
        use_rs = 0; use_rt = 0; bpc = 32'h0; rn = 5'd0; rs = 5'd0; rt = 5'd0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            sq_left[i] = 0; tk_n[i] = 0; st_n[i] = 0;
        end
    endtask

    // One clock: compare outputs at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        bit t, lu;
        logic [3:0]  exp_ctl, got_ctl;
        logic [31:0] exp_tgt, got_tgt;
        logic [63:0] got_tk, got_st;
        string nm;
        @(negedge clk);
        t  = jmp | (beq & zero) | (bne & ~zero);
        lu = m2reg && wreg && (rn != 0) && ((use_rs && rs == rn) || (use_rt && rt == rn));
        for (int i = 0; i < 2; i++) begin
            // ctl packing: {pc_redirect, stall, flush_if_id, flush_id_exe}
            exp_ctl = 4'b0000;
            exp_tgt = 32'h0;
            if (clrn) begin
                if (sq_left[i] > 0)  exp_ctl = 4'b0011;
                else if (t)          begin exp_ctl = 4'b1011; exp_tgt = bpc; end
                else if (lu)         exp_ctl = 4'b0101;
            end
            if (i == 0) begin
                nm = "a";
                got_ctl = {bus_a.pc_redirect, bus_a.stall, bus_a.flush_if_id, bus_a.flush_id_exe};
                got_tgt = bus_a.pc_target;
                got_tk = 64'(bus_a.taken_cnt); got_st = 64'(bus_a.stall_cnt);
            end else begin
                nm = "b";
                got_ctl = {bus_b.pc_redirect, bus_b.stall, bus_b.flush_if_id, bus_b.flush_id_exe};
                got_tgt = bus_b.pc_target;
                got_tk = 64'(bus_b.taken_cnt); got_st = 64'(bus_b.stall_cnt);
            end
            check({nm, ".ctl"},       64'(got_ctl), 64'(exp_ctl));
            check({nm, ".pc_target"}, 64'(got_tgt), 64'(exp_tgt));
            check({nm, ".taken_cnt"}, got_tk, tk_n[i]);
            check({nm, ".stall_cnt"}, got_st, st_n[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!clrn) begin
                sq_left[i] = 0; tk_n[i] = 0; st_n[i] = 0;
            end else if (sq_left[i] > 0) begin
                sq_left[i]--;
            end else if (t) begin
                if (tk_n[i] < cnt_max[i]) tk_n[i]++;
                sq_left[i] = sq_len[i] - 1;
            end else if (lu) begin
                if (st_n[i] < cnt_max[i]) st_n[i]++;
            end
        end
        #1;
    endtask

    initial begin
        idle();
        clrn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cycle();                               // reset values
        clrn = 1'b1;

        beq = 1; zero = 1; bpc = 32'h40;       // taken beq
        cycle();
        idle();
        repeat (3) cycle();                    // squash tail then quiet

        bne = 1; zero = 1; bpc = 32'h80;       // not-taken bne
        cycle();
        idle(); jmp = 1; bpc = 32'h100;        // jump
        cycle();
        idle();
        repeat (2) cycle();

        m2reg = 1; wreg = 1; rn = 5; rs = 5; use_rs = 1;   // load-use
        cycle();
        rn = 0; rs = 0;                                    // r0 never stalls
        cycle();

        rn = 7; rt = 7; use_rt = 1; use_rs = 0;            // taken beq with load-use
        beq = 1; zero = 1; bpc = 32'h200;
        cycle();
        beq = 0;                                           // load-use during squash
        cycle();
        idle();
        cycle();

        jmp = 1; bpc = 32'h300;                // reset during squash
        cycle();
        idle(); clrn = 1'b0;
        cycle();
        clrn = 1'b1;
        cycle();

        jmp = 1; bpc = 32'h400;                // saturation on the 4-bit instance
        repeat (20) cycle();
        idle();
        @(negedge clk);
        check("b.taken_cnt_sat", 64'(bus_b.taken_cnt), 64'd15);
        @(posedge clk); #1;

        clrn = 1'b0;
        cycle();
        clrn = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            clrn   = ($urandom_range(0, 59) != 0);
            beq    = ($urandom_range(0, 5) == 0);
            bne    = ($urandom_range(0, 5) == 0);
            jmp    = ($urandom_range(0, 9) == 0);
            zero   = 1'($urandom_range(0, 1));
            bpc    = $urandom;
            m2reg  = ($urandom_range(0, 2) == 0);
            wreg   = ($urandom_range(0, 3) != 0);
            rn     = 5'($urandom_range(0, 3));
            rs     = 5'($urandom_range(0, 3));
            rt     = 5'($urandom_range(0, 3));
            use_rs = 1'($urandom_range(0, 1));
            use_rt = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
